// File: rtl/speck_ti_pkg.sv
// Shared constants for the 3-share Speck128/128 serial loader.
// State encodings, word geometry and carry-init reset shares live here.
package speck_ti_pkg;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned CNT_W = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic CARRY_RST_A = 1'b1;
  localparam logic CARRY_RST_B = 1'b0;
  localparam logic CARRY_RST_C = 1'b1;

  // Share a completes the XOR so that a ^ b ^ c == value with b = r0, c = r1.
  function automatic logic ti_share_a(input logic value, input logic r0, input logic r1);
    return value ^ r0 ^ r1;
  endfunction

endpackage

// File: rtl/ti_bit_masker.sv
// Splits one bit into three registered Boolean shares (a, b, c) with a^b^c == bit.
// Each share has its own flop so no recombination glitch reaches the core.
module ti_bit_masker
  import speck_ti_pkg::*;
#(
  parameter logic RST_A = 1'b0,
  parameter logic RST_B = 1'b0,
  parameter logic RST_C = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_bit,
  input  logic i_r0,
  input  logic i_r1,
  output logic o_a,
  output logic o_b,
  output logic o_c
);

  logic r_a;
  logic r_b;
  logic r_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= RST_A;
      r_b <= RST_B;
      r_c <= RST_C;
    end else if (i_en) begin
      r_a <= ti_share_a(i_bit, i_r0, i_r1);
      r_b <= i_r0;
      r_c <= i_r1;
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;
  assign o_c = r_c;

endmodule

// File: rtl/speck_ti_share_loader.sv
// Serial 3-share feeder for the bit-serial Speck128/128 core: accepts pt/key,
// shifts masked shares LSB-first under we, then holds Start until core_done.
module speck_ti_share_loader
  import speck_ti_pkg::*;
#(
  parameter int unsigned WIDTH   = speck_ti_pkg::WIDTH,
  parameter int unsigned CNT_W   = speck_ti_pkg::CNT_W,
  parameter int unsigned MASK_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pt,
  input  logic [WIDTH-1:0] key,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [5:0]       rnd,
  input  logic             core_done,
  output logic             data_ina,
  output logic             data_inb,
  output logic             data_inc,
  output logic             k_data_ina,
  output logic             k_data_inb,
  output logic             k_data_inc,
  output logic             carry_init_a,
  output logic             carry_init_b,
  output logic             carry_init_c,
  output logic             we,
  output logic             Start,
  output logic             busy
);

  localparam logic L_MASK = (MASK_EN != 0);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_pt_sr;
  logic [WIDTH-1:0] r_key_sr;
  logic             r_we;
  logic             r_start;
  logic             r_busy;
  logic             r_ready;

  logic w_shift;
  logic w_accept;
  logic w_d_bit, w_d_r0, w_d_r1;
  logic w_k_bit, w_k_r0, w_k_r1;
  logic w_c_r0, w_c_r1;

  assign w_shift  = (r_state == ST_SHIFT);
  assign w_accept = (r_state == ST_IDLE) & load_valid;

  // Outside SHIFT every input to the data/key maskers is forced low, so the
  // share outputs settle to 0 on the first RUN cycle.
  assign w_d_bit = w_shift & r_pt_sr[0];
  assign w_d_r0  = w_shift & L_MASK & rnd[0];
  assign w_d_r1  = w_shift & L_MASK & rnd[1];
  assign w_k_bit = w_shift & r_key_sr[0];
  assign w_k_r0  = w_shift & L_MASK & rnd[2];
  assign w_k_r1  = w_shift & L_MASK & rnd[3];

  // Carry shares encode 0: with r = rnd[4], s = rnd[5] the masker yields
  // a = r, b = s, c = r ^ s; unmasked it yields 1/0/1.
  assign w_c_r0 = L_MASK ? rnd[5] : 1'b0;
  assign w_c_r1 = L_MASK ? (rnd[4] ^ rnd[5]) : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pt_sr  <= '0;
      r_key_sr <= '0;
      r_we     <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_we    <= 1'b0;
          r_start <= 1'b0;
          if (load_valid) begin
            r_pt_sr  <= pt;
            r_key_sr <= key;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_we     <= 1'b1;
          r_pt_sr  <= r_pt_sr >> 1;
          r_key_sr <= r_key_sr >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_we <= 1'b0;
          // core_done only counts once Start is visible to the core.
          if (r_start && core_done) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_start <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ti_bit_masker #(.RST_A(1'b0), .RST_B(1'b0), .RST_C(1'b0)) u_data_mask (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_bit(w_d_bit),
    .i_r0 (w_d_r0),
    .i_r1 (w_d_r1),
    .o_a  (data_ina),
    .o_b  (data_inb),
    .o_c  (data_inc)
  );

  ti_bit_masker #(.RST_A(1'b0), .RST_B(1'b0), .RST_C(1'b0)) u_key_mask (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_bit(w_k_bit),
    .i_r0 (w_k_r0),
    .i_r1 (w_k_r1),
    .o_a  (k_data_ina),
    .o_b  (k_data_inb),
    .o_c  (k_data_inc)
  );

  ti_bit_masker #(.RST_A(CARRY_RST_A), .RST_B(CARRY_RST_B), .RST_C(CARRY_RST_C)) u_carry_mask (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_accept),
    .i_bit(1'b0),
    .i_r0 (w_c_r0),
    .i_r1 (w_c_r1),
    .o_a  (carry_init_a),
    .o_b  (carry_init_b),
    .o_c  (carry_init_c)
  );

  assign we         = r_we;
  assign Start      = r_start;
  assign busy       = r_busy;
  assign load_ready = r_ready;

endmodule

// File: doc/speck_ti_share_loader.md
Name: speck_ti_share_loader

Overview:
- Upstream feeder for the bit-serial 3-share Speck128/128 core.
- Accepts a 128-bit plaintext and a 128-bit key in parallel and splits each into three Boolean shares using fresh per-cycle randomness.
- Shifts the shares into the core LSB-first, one bit per cycle, with `we` high, then asserts `Start` and holds it until the core signals completion.
- Also drives the core's three carry-init shares.

Parameters:
- WIDTH, 128, plaintext/key word width in bits; equals the number of shift cycles.
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W == WIDTH.
- MASK_EN, 1: 1 = random masking; 0 = share a carries the value, shares b/c are 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pt  in  WIDTH  plaintext; sampled on accept.
- key  in  WIDTH  key; sampled on accept.
- load_valid  in  1  request to load pt/key.
- load_ready  out  1  loader idle; a request can be accepted.
- rnd  in  6  fresh random bits each cycle: [1:0] data masks, [3:2] key masks, [5:4] carry masks (used on accept only).
- core_done  in  1  completion pulse from the core.
- data_ina, data_inb, data_inc  out  1 each  serial plaintext shares.
- k_data_ina, k_data_inb, k_data_inc  out  1 each  serial key shares.
- carry_init_a, carry_init_b, carry_init_c  out  1 each  carry-init shares; XOR of the three = 0.
- we  out  1  core write enable.
- Start  out  1  core run enable.
- busy  out  1  loader is not in IDLE.

Behaviour:
- Reset: all outputs registered. State = IDLE; counter = 0; we = Start = busy = 0; all data/key share outputs = 0; carry_init_a/b/c = 1/0/1; load_ready = 1.
- State IDLE:
  - load_ready = 1.
  - On load_valid & load_ready: latch pt and key into shift registers; latch rnd[5:4] as carry masks r, s; go to SHIFT.
  - Carry outputs become a = r, b = s, c = r^s. With MASK_EN = 0 they become 1/0/1.
- State SHIFT, WIDTH cycles; first bit appears on the cycle after accept:
  - we = 1.
  - Bit i = shift-register LSB.
  - Data shares: b = rnd[0], c = rnd[1], a = bit ^ rnd[0] ^ rnd[1]. Key shares are formed the same way from rnd[3:2].
  - Shift registers shift right by one bit; counter increments.
  - After the cycle presenting bit WIDTH-1 (counter wraps 127→0), go to RUN.
- State RUN:
  - we = 0; Start = 1, asserted in the cycle directly after the last we cycle.
  - Share outputs drive 0; carry shares stay stable.
  - Hold until core_done = 1, then Start = 0 on the next cycle and go to IDLE.
- Output timing: exactly WIDTH consecutive we cycles with no gaps.
- Accept latency: 1 cycle from the accepting edge to the first we.
- load_valid outside IDLE: ignored (load_ready = 0), no queuing.
- core_done during SHIFT: ignored.
- core_done in the same cycle Start first rises: honoured, giving a 1-cycle Start pulse.
- rst mid-SHIFT or mid-RUN: next cycle all outputs take their reset values; the partial load is discarded.
- The unmasked value never appears on any single output when MASK_EN = 1 and rnd is uniform.
- Only combinational XOR of registered bits feeds the share outputs. Each share is registered separately, so no glitch recombination occurs.

Decomposition:
- Shared package speck_ti_pkg holds:
  - state encoding (IDLE, SHIFT, RUN);
  - WIDTH = 128 and CNT_W = 7 constants;
  - carry-init reset constants 1/0/1.
- One natural sub-module: ti_bit_masker. Maps (bit, r0, r1) to registered shares (a, b, c); instantiated three times (data, key, carry).

Test Plan:
- MASK_EN = 0, pt = 0x6c617669757165207469206564616d20, key = 0x0f0e0d0c0b0a09080706050403020100 -> 128 we cycles; data_ina sequence equals pt LSB-first, k_data_ina equals key LSB-first, b/c always 0; Start rises on cycle 129 after accept.
- MASK_EN = 1, same vectors, random rnd -> per cycle a^b^c equals the expected bit for both data and key; carry a^b^c = 0; b and c equal the rnd bits applied.
- In RUN, pulse core_done 50 cycles after Start -> Start falls the next cycle, load_ready = 1; new load_valid accepted.
- load_valid held high during SHIFT and RUN -> no second accept; we count stays exactly 128.
- rst asserted at shift cycle 64 -> next cycle we = 0, Start = 0, carry = 1/0/1, load_ready = 1; a subsequent load completes with the full 128 cycles.
- core_done = 1 already on the first RUN cycle -> Start high for exactly 1 cycle.
